// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: LED/HEX output registers, synchronised and
// debounced key/switch inputs, sticky ready/overrun status and interrupt.
module mmio_io_ctrl #(
  parameter int unsigned      DBITS           = 32,
  parameter int unsigned      KEY_BITS        = 4,
  parameter int unsigned      SW_BITS         = 10,
  parameter int unsigned      LEDR_BITS       = 10,
  parameter int unsigned      LEDG_BITS       = 8,
  parameter int unsigned      HEX_DIGITS      = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 100000,
  parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_LEDG       = 32'hF0000008,
  parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SDATA      = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DBITS-1:0]        addr,
  input  logic                    wrtEn,
  input  logic                    rdEn,
  input  logic [DBITS-1:0]        dIn,
  output logic [DBITS-1:0]        dOut,
  output logic                    hit,
  input  logic [KEY_BITS-1:0]     key,
  input  logic [SW_BITS-1:0]      sw,
  output logic [LEDR_BITS-1:0]    ledr,
  output logic [LEDG_BITS-1:0]    ledg,
  output logic [4*HEX_DIGITS-1:0] hex,
  output logic                    intr
);
  localparam int unsigned HB = 4 * HEX_DIGITS;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [KEY_BITS-1:0] k_s1, k_s2, k_deb, k_upd;
  logic [SW_BITS-1:0]  s_s1, s_s2, s_deb, s_upd;
  logic [CW-1:0]       k_cnt [KEY_BITS];
  logic [CW-1:0]       s_cnt [SW_BITS];
  logic k_rdy, k_ovr, k_ie, s_rdy, s_ovr, s_ie;
  logic k_ev, s_ev;
  logic sel_hex, sel_ledr, sel_ledg, sel_kdata, sel_sdata, sel_kctrl, sel_sctrl;
  logic unused_dbits;

  assign unused_dbits = ^dIn;

  assign sel_hex   = (addr == ADDR_HEX);
  assign sel_ledr  = (addr == ADDR_LEDR);
  assign sel_ledg  = (addr == ADDR_LEDG);
  assign sel_kdata = (addr == ADDR_KDATA);
  assign sel_sdata = (addr == ADDR_SDATA);
  assign sel_kctrl = (addr == ADDR_KCTRL);
  assign sel_sctrl = (addr == ADDR_SCTRL);

  // A bit is accepted on the edge where its counter sits at the last value and it still differs.
  always_comb begin
    k_upd = '0;
    s_upd = '0;
    for (int unsigned i = 0; i < KEY_BITS; i++)
      k_upd[i] = (k_s2[i] != k_deb[i]) && (k_cnt[i] == CNT_LAST);
    for (int unsigned i = 0; i < SW_BITS; i++)
      s_upd[i] = (s_s2[i] != s_deb[i]) && (s_cnt[i] == CNT_LAST);
  end

  assign k_ev = |k_upd;
  assign s_ev = |s_upd;

  always_ff @(posedge clk) begin
    if (reset) begin
      k_s1 <= '0; k_s2 <= '0; k_deb <= '0;
      s_s1 <= '0; s_s2 <= '0; s_deb <= '0;
      for (int unsigned i = 0; i < KEY_BITS; i++) k_cnt[i] <= '0;
      for (int unsigned i = 0; i < SW_BITS; i++)  s_cnt[i] <= '0;
      k_rdy <= 1'b0; k_ovr <= 1'b0; k_ie <= 1'b0;
      s_rdy <= 1'b0; s_ovr <= 1'b0; s_ie <= 1'b0;
      ledr <= '0; ledg <= '0; hex <= '0;
      intr <= 1'b0;
    end else begin
      k_s1 <= ~key; k_s2 <= k_s1;
      s_s1 <= sw;   s_s2 <= s_s1;

      for (int unsigned i = 0; i < KEY_BITS; i++) begin
        if (k_s2[i] == k_deb[i]) k_cnt[i] <= '0;
        else if (k_upd[i]) begin
          k_deb[i] <= k_s2[i];
          k_cnt[i] <= '0;
        end else k_cnt[i] <= k_cnt[i] + 1'b1;
      end
      for (int unsigned i = 0; i < SW_BITS; i++) begin
        if (s_s2[i] == s_deb[i]) s_cnt[i] <= '0;
        else if (s_upd[i]) begin
          s_deb[i] <= s_s2[i];
          s_cnt[i] <= '0;
        end else s_cnt[i] <= s_cnt[i] + 1'b1;
      end

      // Set events take priority over any clear in the same cycle.
      if (k_ev) k_rdy <= 1'b1;
      else if ((wrtEn && sel_kctrl && !dIn[0]) || (rdEn && sel_kdata)) k_rdy <= 1'b0;
      if (k_ev && k_rdy) k_ovr <= 1'b1;
      else if (wrtEn && sel_kctrl && !dIn[1]) k_ovr <= 1'b0;
      if (wrtEn && sel_kctrl) k_ie <= dIn[8];

      if (s_ev) s_rdy <= 1'b1;
      else if ((wrtEn && sel_sctrl && !dIn[0]) || (rdEn && sel_sdata)) s_rdy <= 1'b0;
      if (s_ev && s_rdy) s_ovr <= 1'b1;
      else if (wrtEn && sel_sctrl && !dIn[1]) s_ovr <= 1'b0;
      if (wrtEn && sel_sctrl) s_ie <= dIn[8];

      if (wrtEn && sel_hex)  hex  <= dIn[HB-1:0];
      if (wrtEn && sel_ledr) ledr <= dIn[LEDR_BITS-1:0];
      if (wrtEn && sel_ledg) ledg <= dIn[LEDG_BITS-1:0];

      intr <= (k_rdy & k_ie) | (s_rdy & s_ie);
    end
  end

  always_comb begin
    dOut = '0;
    hit  = 1'b1;
    case (addr)
      ADDR_HEX:   dOut[HB-1:0]        = hex;
      ADDR_LEDR:  dOut[LEDR_BITS-1:0] = ledr;
      ADDR_LEDG:  dOut[LEDG_BITS-1:0] = ledg;
      ADDR_KDATA: dOut[KEY_BITS-1:0]  = k_deb;
      ADDR_SDATA: dOut[SW_BITS-1:0]   = s_deb;
      ADDR_KCTRL: begin dOut[0] = k_rdy; dOut[1] = k_ovr; dOut[8] = k_ie; end
      ADDR_SCTRL: begin dOut[0] = s_rdy; dOut[1] = s_ovr; dOut[8] = s_ie; end
      default:    hit = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Scoreboard bench for mmio_io_ctrl with a short debounce window.
module tb_mmio_io_ctrl;
  localparam logic [31:0] A_HEX   = 32'hF0000000;
  localparam logic [31:0] A_LEDR  = 32'hF0000004;
  localparam logic [31:0] A_LEDG  = 32'hF0000008;
  localparam logic [31:0] A_KDATA = 32'hF0000010;
  localparam logic [31:0] A_SDATA = 32'hF0000014;
  localparam logic [31:0] A_KCTRL = 32'hF0000110;
  localparam logic [31:0] A_SCTRL = 32'hF0000114;
  localparam logic [31:0] A_NONE  = 32'hF0000018;

  logic        clk = 1'b0;
  logic        reset, wrtEn, rdEn, hit, intr;
  logic [31:0] addr, dIn, dOut;
  logic [3:0]  key;
  logic [9:0]  sw, ledr;
  logic [7:0]  ledg;
  logic [15:0] hex;

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] d;
    logic        h;
  } exp_t;
  exp_t sb[$];

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  mmio_io_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wrtEn(wrtEn), .rdEn(rdEn),
    .dIn(dIn), .dOut(dOut), .hit(hit), .key(key), .sw(sw),
    .ledr(ledr), .ledg(ledg), .hex(hex), .intr(intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; dIn = d; wrtEn = 1'b1;
    tick(1);
    wrtEn = 1'b0; dIn = '0;
  endtask

  task automatic bus_load(input logic [31:0] a);
    addr = a; rdEn = 1'b1;
    tick(1);
    rdEn = 1'b0;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic h);
    exp_t e;
    e.tag = tag; e.a = a; e.d = d; e.h = h;
    sb.push_back(e);
  endtask

  // Side-effect-free reads (rdEn low) of every queued expectation.
  task automatic sb_drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addr = e.a;
      #1;
      check(e.tag, dOut, e.d);
      check({e.tag, ".hit"}, {31'b0, hit}, {31'b0, e.h});
    end
  endtask

  initial begin
    reset = 1'b1; wrtEn = 1'b0; rdEn = 1'b0; addr = '0; dIn = '0;
    key = 4'hF; sw = '0;
    tick(2);
    reset = 1'b0;
    tick(1);

    // 1: reset state and decode
    sb_push("rst.hex", A_HEX, 32'h0, 1'b1);
    sb_push("rst.ledr", A_LEDR, 32'h0, 1'b1);
    sb_push("rst.ledg", A_LEDG, 32'h0, 1'b1);
    sb_push("rst.kdata", A_KDATA, 32'h0, 1'b1);
    sb_push("rst.sdata", A_SDATA, 32'h0, 1'b1);
    sb_push("rst.kctrl", A_KCTRL, 32'h0, 1'b1);
    sb_push("rst.sctrl", A_SCTRL, 32'h0, 1'b1);
    sb_push("unmapped", A_NONE, 32'h0, 1'b0);
    sb_drain();
    check("rst.intr", {31'b0, intr}, 32'h0);

    // 2: key press latency is 2+DEBOUNCE_CYCLES edges
    key = 4'b1110;
    tick(5);
    sb_push("key.early", A_KDATA, 32'h0, 1'b1);
    sb_drain();
    tick(1);
    sb_push("key.kdata", A_KDATA, 32'h1, 1'b1);
    sb_push("key.kctrl", A_KCTRL, 32'h1, 1'b1);
    sb_drain();
    bus_load(A_KDATA);
    sb_push("key.rdclr", A_KCTRL, 32'h0, 1'b1);
    sb_drain();
    check("key.intr", {31'b0, intr}, 32'h0);

    // 3: 3-cycle glitch on sw[3] is filtered
    sw = 10'h008;
    tick(3);
    sw = 10'h000;
    for (int i = 0; i < 8; i++) begin
      sb_push("glitch.sdata", A_SDATA, 32'h0, 1'b1);
      sb_push("glitch.sctrl", A_SCTRL, 32'h0, 1'b1);
      sb_drain();
      tick(1);
    end

    // 4: switch interrupt
    bus_write(A_SCTRL, 32'h100);
    sb_push("sw.ie", A_SCTRL, 32'h100, 1'b1);
    sb_drain();
    sw = 10'h3FF;
    tick(6);
    sb_push("sw.sdata", A_SDATA, 32'h3FF, 1'b1);
    sb_push("sw.sctrl", A_SCTRL, 32'h101, 1'b1);
    sb_drain();
    check("sw.intr_lag", {31'b0, intr}, 32'h0);
    tick(1);
    check("sw.intr", {31'b0, intr}, 32'h1);
    bus_write(A_SCTRL, 32'h100);
    sb_push("sw.clr", A_SCTRL, 32'h100, 1'b1);
    sb_drain();
    check("sw.intr_hold", {31'b0, intr}, 32'h1);
    tick(1);
    check("sw.intr_off", {31'b0, intr}, 32'h0);

    // 5: overrun
    key = 4'b1100;
    tick(6);
    sb_push("ovr.rdy", A_KCTRL, 32'h1, 1'b1);
    sb_drain();
    key = 4'b1000;
    tick(6);
    sb_push("ovr.kdata", A_KDATA, 32'h7, 1'b1);
    sb_push("ovr.kctrl", A_KCTRL, 32'h3, 1'b1);
    sb_drain();
    bus_write(A_KCTRL, 32'h1);
    sb_push("ovr.clr1", A_KCTRL, 32'h1, 1'b1);
    sb_drain();
    bus_write(A_KCTRL, 32'h0);
    sb_push("ovr.clr0", A_KCTRL, 32'h0, 1'b1);
    sb_drain();

    // 6: output registers, unmapped store, reset
    bus_write(A_HEX, 32'hFFFFABCD);
    bus_write(A_LEDR, 32'h3FF);
    bus_write(A_LEDG, 32'h1A5);
    bus_write(A_NONE, 32'h0);
    bus_write(A_KDATA, 32'h0);
    check("out.hex", {16'b0, hex}, 32'hABCD);
    check("out.ledr", {22'b0, ledr}, 32'h3FF);
    check("out.ledg", {24'b0, ledg}, 32'hA5);
    sb_push("rb.hex", A_HEX, 32'h0000ABCD, 1'b1);
    sb_push("rb.ledr", A_LEDR, 32'h3FF, 1'b1);
    sb_push("rb.ledg", A_LEDG, 32'hA5, 1'b1);
    sb_push("rb.kdata", A_KDATA, 32'h7, 1'b1);
    sb_drain();
    key = 4'b1111;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst2.hex", {16'b0, hex}, 32'h0);
    check("rst2.ledr", {22'b0, ledr}, 32'h0);
    check("rst2.ledg", {24'b0, ledg}, 32'h0);
    sb_push("rst2.kdata", A_KDATA, 32'h0, 1'b1);
    sb_push("rst2.sdata", A_SDATA, 32'h0, 1'b1);
    sb_push("rst2.sctrl", A_SCTRL, 32'h0, 1'b1);
    sb_drain();
    // switches still high after reset register as a fresh change
    tick(6);
    sb_push("rst2.sw", A_SDATA, 32'h3FF, 1'b1);
    sb_push("rst2.srdy", A_SCTRL, 32'h1, 1'b1);
    sb_push("rst2.kctrl", A_KCTRL, 32'h0, 1'b1);
    sb_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
